// File: rtl/latch_loader.sv
// Front end for a bank of gated D latches: takes words over valid/ready and
// sequences data-setup, a registered ST pulse, and data-hold for each one.
module latch_loader #(
  parameter int WIDTH = 8,
  parameter int SETUP = 1,
  parameter int PULSE = 2,
  parameter int HOLD  = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic [WIDTH-1:0] OUT_D,
  output logic             OUT_ST,
  output logic             BUSY,
  output logic             DONE
);

  localparam int MAX_CNT = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                           : ((PULSE > HOLD) ? PULSE : HOLD);
  localparam int CW = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             buf_full_q, buf_full_d;
  logic             ready_q, ready_d;
  logic             st_q, st_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic hs;
  logic last;

  assign IN_READY = ready_q & ~RST;
  assign hs       = IN_VALID & IN_READY;
  assign last     = (cnt_q == CW'(1));

  assign OUT_D  = act_q;
  assign OUT_ST = st_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      act_q      <= '0;
      skid_q     <= '0;
      buf_full_q <= 1'b0;
      ready_q    <= 1'b0;
      st_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      skid_q     <= skid_d;
      buf_full_q <= buf_full_d;
      ready_q    <= ready_d;
      st_q       <= st_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_d      = act_q;
    skid_d     = skid_q;
    buf_full_d = buf_full_q;

    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          act_d   = IN_DATA;
          state_d = S_SETUP;
          cnt_d   = CW'(SETUP);
        end
      end
      S_SETUP: begin
        if (last) begin
          state_d = S_STROBE;
          cnt_d   = CW'(PULSE);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STROBE: begin
        if (last) begin
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (!last) begin
          cnt_d = cnt_q - CW'(1);
        end else if (buf_full_q) begin
          act_d      = skid_q;
          buf_full_d = 1'b0;
          state_d    = S_SETUP;
          cnt_d      = CW'(SETUP);
        end else if (hs) begin
          act_d   = IN_DATA;
          state_d = S_SETUP;
          cnt_d   = CW'(SETUP);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A word arriving mid-sequence parks in the skid register; at the
    // final HOLD edge it goes straight to ACT instead (handled above).
    if (hs && state_q != S_IDLE && !(state_q == S_HOLD && last)) begin
      skid_d     = IN_DATA;
      buf_full_d = 1'b1;
    end
  end

  // Outputs are decoded from next-state so they leave the block as flops.
  always_comb begin
    st_d    = (state_d == S_STROBE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_HOLD) && (cnt_d == CW'(1));
    ready_d = ~buf_full_d;
  end

endmodule

// File: tb/tb_latch_loader.sv
// Bench for latch_loader: table-driven cycle vectors, directed corner cases,
// and a scoreboarded random stream checked against a behavioural latch bank.
module tb_latch_loader;

  logic       clk;
  logic       rst, in_valid, in_ready, out_st, busy, done;
  logic [7:0] in_data, out_d;
  logic       p_rst, p_valid, p_ready, p_st, p_busy, p_done;
  logic [7:0] p_data, p_d;
  logic [7:0] latch_q;

  int n_checks = 0;
  int n_pass   = 0;

  latch_loader #(.WIDTH(8)) u_dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_DATA(in_data), .OUT_D(out_d), .OUT_ST(out_st), .BUSY(busy), .DONE(done)
  );

  latch_loader #(.WIDTH(8), .SETUP(3), .PULSE(1), .HOLD(2)) u_p (
    .CLK(clk), .RST(p_rst), .IN_VALID(p_valid), .IN_READY(p_ready),
    .IN_DATA(p_data), .OUT_D(p_d), .OUT_ST(p_st), .BUSY(p_busy), .DONE(p_done)
  );

  // Downstream gated D latch bank sharing one strobe.
  always_latch begin
    if (rst)         latch_q <= 8'h00;
    else if (out_st) latch_q <= out_d;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic       rst, vld;
    logic [7:0] data;
    logic       rdy;
    logic [7:0] d;
    logic       st, busy, done;
    logic [7:0] lat;
  } vec_t;

  vec_t vecs[26];

  initial begin
    logic [7:0] q_exp[$];
    logic [7:0] exp_w, prev_d;
    logic       prev_busy, prev_done, prev_st;
    int         accepted, cycles, done_cnt, strobe_cnt;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    p_rst = 1'b1; p_valid = 1'b0; p_data = 8'h00;

    //            rst   vld   data   rdy   d      st    busy  done  latch
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[8]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[9]  = '{1'b0, 1'b1, 8'h22, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h11};
    vecs[10] = '{1'b0, 1'b1, 8'h99, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h11};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h22};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h22};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h22};
    vecs[17] = '{1'b0, 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h22};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C};
    vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C};
    vecs[21] = '{1'b0, 1'b1, 8'hC3, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[22] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 8'hC3};
    vecs[23] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 8'hC3};
    vecs[24] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3};
    vecs[25] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 8'hC3};

    // Row i drives the inputs sampled at an edge and lists the outputs
    // expected in the cycle that follows it.
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; in_valid = vecs[i].vld; in_data = vecs[i].data;
      @(posedge clk); #1;
      check($sformatf("row%0d_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      check($sformatf("row%0d_out_d", i), 32'(out_d),   32'(vecs[i].d));
      check($sformatf("row%0d_out_st", i), 32'(out_st), 32'(vecs[i].st));
      check($sformatf("row%0d_busy", i), 32'(busy),     32'(vecs[i].busy));
      check($sformatf("row%0d_done", i), 32'(done),     32'(vecs[i].done));
      check($sformatf("row%0d_latch", i), 32'(latch_q), 32'(vecs[i].lat));
    end

    // Reset in the middle of a strobe with a word sitting in the skid buffer.
    @(negedge clk); in_valid = 1'b1; in_data = 8'h5A;
    @(posedge clk); #1;
    @(negedge clk); in_valid = 1'b1; in_data = 8'h77;
    @(posedge clk); #1;
    check("rst_pre_st", 32'(out_st), 32'(1));
    check("rst_pre_ready", 32'(in_ready), 32'(0));
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_st", 32'(out_st), 32'(0));
    check("rst_out_d", 32'(out_d), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ready", 32'(in_ready), 32'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_ready", 32'(in_ready), 32'(1));
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rst_discard_d%0d", k), 32'(out_d), 32'(0));
      check($sformatf("rst_discard_busy%0d", k), 32'(busy), 32'(0));
      @(posedge clk); #1;
    end

    // SETUP=3, PULSE=1, HOLD=2 instance.
    @(negedge clk); p_rst = 1'b0;
    @(posedge clk); #1;
    check("p_ready", 32'(p_ready), 32'(1));
    @(negedge clk); p_valid = 1'b1; p_data = 8'hFF;
    @(posedge clk); #1;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) begin
        @(negedge clk); p_valid = 1'b0;
        @(posedge clk); #1;
      end
      check($sformatf("p_st_c%0d", k), 32'(p_st), 32'(k == 3));
      check($sformatf("p_done_c%0d", k), 32'(p_done), 32'(k == 5));
      check($sformatf("p_busy_c%0d", k), 32'(p_busy), 32'(k <= 5));
      if (k <= 5) check($sformatf("p_d_c%0d", k), 32'(p_d), 32'(8'hFF));
    end

    // Random stream against a scoreboard of accepted words.
    accepted = 0; cycles = 0; done_cnt = 0; strobe_cnt = 0;
    prev_d = out_d; prev_busy = busy; prev_done = done; prev_st = out_st;
    while ((accepted < 1000 || q_exp.size() != 0 || busy) && cycles < 20000) begin
      @(negedge clk);
      in_valid = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      if (in_valid && in_ready) begin
        q_exp.push_back(in_data);
        accepted++;
      end
      @(posedge clk); #1;
      cycles++;
      if (prev_busy && !prev_done)
        check("rand_d_stable", 32'(out_d), 32'(prev_d));
      if (out_st && !prev_st) strobe_cnt++;
      if (done) begin
        exp_w = (q_exp.size() > 0) ? q_exp.pop_front() : 8'hxx;
        done_cnt++;
        check("rand_latch_word", 32'(latch_q), 32'(exp_w));
        check("rand_out_d_word", 32'(out_d), 32'(exp_w));
      end
      prev_d = out_d; prev_busy = busy; prev_done = done; prev_st = out_st;
    end
    in_valid = 1'b0;
    check("rand_accepted", 32'(accepted), 32'(1000));
    check("rand_drained", 32'(q_exp.size()), 32'(0));
    check("rand_done_count", 32'(done_cnt), 32'(1000));
    check("rand_strobe_count", 32'(strobe_cnt), 32'(1000));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
